// File: rtl/axis_lrelu_input_sequencer_if.sv
// rtl/axis_lrelu_input_sequencer_if.sv - AXIS-style beat bundle shared by the sequencer's config, data and output streams
//
// Purpose: one stream of tdata/tuser/tlast beats with a valid/ready handshake.
//   is_config is only meaningful on the merged output stream.
// Modports:
//   master - drives tvalid/tdata/tuser/tlast/is_config, samples tready
//   slave  - samples tvalid/tdata/tuser/tlast, drives tready
interface axis_lrelu_input_sequencer_if #(
    parameter int DATA_WIDTH = 256,
    parameter int USER_WIDTH = 16
);
    logic                  tvalid;
    logic                  tready;
    logic [DATA_WIDTH-1:0] tdata;
    logic [USER_WIDTH-1:0] tuser;
    logic                  tlast;
    logic                  is_config;

    modport master (
        output tvalid,
        output tdata,
        output tuser,
        output tlast,
        output is_config,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        input  tuser,
        input  tlast,
        output tready
    );
endinterface

// File: rtl/axis_lrelu_input_sequencer.sv
// rtl/axis_lrelu_input_sequencer.sv - merges config and conv data streams into one registered LReLU input stream
//
// Purpose: per iteration, forwards the config beats (2 for a 1x1 kernel, 8 for 3x3,
//   chosen by the kh2 field of the first config beat), then data beats up to and
//   including data tlast. Output is a single registered stage.
// Ports:
//   aclk, aresetn - clock, asynchronous active-low reset
//   s_cfg         - config stream in (slave)
//   s_dat         - conv data stream in (slave)
//   m_axis        - merged stream out (master); is_config flags config beats
//   iter_count    - completed iterations, wraps to 0
//   cfg_error     - sticky: config tlast disagreed with the expected beat count
module axis_lrelu_input_sequencer #(
    parameter int DATA_WIDTH    = 256,
    parameter int USER_WIDTH    = 16,
    parameter int I_KH2         = 0,
    parameter int BITS_KH2      = 1,
    parameter int CFG_BEATS_1X1 = 2,
    parameter int CFG_BEATS_3X3 = 8,
    parameter int ITER_BITS     = 16
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    axis_lrelu_input_sequencer_if.slave  s_cfg,
    axis_lrelu_input_sequencer_if.slave  s_dat,
    axis_lrelu_input_sequencer_if.master m_axis,
    output logic [ITER_BITS-1:0]         iter_count,
    output logic                         cfg_error
);
    localparam int CFG_MAX = (CFG_BEATS_3X3 > CFG_BEATS_1X1) ? CFG_BEATS_3X3 : CFG_BEATS_1X1;
    // cfg_count holds the number of config beats still to come after the next one (max CFG_MAX-2)
    localparam int CNT_W   = (CFG_MAX > 2) ? $clog2(CFG_MAX - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_1X1 = CNT_W'(CFG_BEATS_1X1 - 2);
    localparam logic [CNT_W-1:0] CNT_3X3 = CNT_W'(CFG_BEATS_3X3 - 2);

    typedef enum logic [1:0] {
        CFG_FIRST = 2'd0,
        CFG_REST  = 2'd1,
        DATA      = 2'd2
    } state_t;

    state_t                state_q,      state_d;
    logic [CNT_W-1:0]      cfg_count_q,  cfg_count_d;
    logic [ITER_BITS-1:0]  iter_count_q, iter_count_d;
    logic                  cfg_error_q,  cfg_error_d;
    logic                  m_tvalid_q,   m_tvalid_d;
    logic [DATA_WIDTH-1:0] m_tdata_q,    m_tdata_d;
    logic [USER_WIDTH-1:0] m_tuser_q,    m_tuser_d;
    logic                  m_tlast_q,    m_tlast_d;
    logic                  m_is_cfg_q,   m_is_cfg_d;

    logic load_en;
    logic in_cfg;
    logic cfg_hs;
    logic dat_hs;
    logic kh2_nz;

    // Ready depends only on state and the output stage, never on either input's valid
    assign load_en      = !m_tvalid_q || m_axis.tready;
    assign in_cfg       = (state_q != DATA);
    assign s_cfg.tready = load_en && in_cfg;
    assign s_dat.tready = load_en && !in_cfg;
    assign cfg_hs       = s_cfg.tvalid && s_cfg.tready;
    assign dat_hs       = s_dat.tvalid && s_dat.tready;
    assign kh2_nz       = |s_cfg.tuser[I_KH2 +: BITS_KH2];

    always_comb begin
        state_d      = state_q;
        cfg_count_d  = cfg_count_q;
        iter_count_d = iter_count_q;
        cfg_error_d  = cfg_error_q;
        m_tvalid_d   = m_tvalid_q;
        m_tdata_d    = m_tdata_q;
        m_tuser_d    = m_tuser_q;
        m_tlast_d    = m_tlast_q;
        m_is_cfg_d   = m_is_cfg_q;

        // The beat count is authoritative; a misplaced s_cfg_tlast only flags an error
        case (state_q)
            CFG_FIRST: begin
                if (cfg_hs) begin
                    cfg_count_d = kh2_nz ? CNT_3X3 : CNT_1X1;
                    state_d     = CFG_REST;
                    if (s_cfg.tlast) cfg_error_d = 1'b1;
                end
            end
            CFG_REST: begin
                if (cfg_hs) begin
                    if (cfg_count_q == '0) begin
                        state_d = DATA;
                        if (!s_cfg.tlast) cfg_error_d = 1'b1;
                    end else begin
                        cfg_count_d = cfg_count_q - CNT_W'(1);
                        if (s_cfg.tlast) cfg_error_d = 1'b1;
                    end
                end
            end
            DATA: begin
                if (dat_hs && s_dat.tlast) begin
                    iter_count_d = iter_count_q + ITER_BITS'(1);
                    state_d      = CFG_FIRST;
                end
            end
            default: state_d = CFG_FIRST;
        endcase

        if (load_en) begin
            m_tvalid_d = cfg_hs || dat_hs;
            if (cfg_hs) begin
                m_tdata_d  = s_cfg.tdata;
                m_tuser_d  = s_cfg.tuser;
                m_tlast_d  = 1'b0;
                m_is_cfg_d = 1'b1;
            end else if (dat_hs) begin
                m_tdata_d  = s_dat.tdata;
                m_tuser_d  = s_dat.tuser;
                m_tlast_d  = s_dat.tlast;
                m_is_cfg_d = 1'b0;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q      <= CFG_FIRST;
            cfg_count_q  <= '0;
            iter_count_q <= '0;
            cfg_error_q  <= 1'b0;
            m_tvalid_q   <= 1'b0;
            m_tdata_q    <= '0;
            m_tuser_q    <= '0;
            m_tlast_q    <= 1'b0;
            m_is_cfg_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cfg_count_q  <= cfg_count_d;
            iter_count_q <= iter_count_d;
            cfg_error_q  <= cfg_error_d;
            m_tvalid_q   <= m_tvalid_d;
            m_tdata_q    <= m_tdata_d;
            m_tuser_q    <= m_tuser_d;
            m_tlast_q    <= m_tlast_d;
            m_is_cfg_q   <= m_is_cfg_d;
        end
    end

    assign m_axis.tvalid    = m_tvalid_q;
    assign m_axis.tdata     = m_tdata_q;
    assign m_axis.tuser     = m_tuser_q;
    assign m_axis.tlast     = m_tlast_q;
    assign m_axis.is_config = m_is_cfg_q;
    assign iter_count       = iter_count_q;
    assign cfg_error        = cfg_error_q;
endmodule

// File: tb/tb_axis_lrelu_input_sequencer.sv
// tb/tb_axis_lrelu_input_sequencer.sv - randomized self-checking bench for axis_lrelu_input_sequencer
module tb_axis_lrelu_input_sequencer;
    localparam int DW = 32;
    localparam int UW = 16;
    localparam int IB = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [IB-1:0] iter_count;
    logic          cfg_error;

    always #5 clk = ~clk;

    axis_lrelu_input_sequencer_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) cfg_if ();
    axis_lrelu_input_sequencer_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) dat_if ();
    axis_lrelu_input_sequencer_if #(.DATA_WIDTH(DW), .USER_WIDTH(UW)) m_if ();

    assign cfg_if.is_config = 1'b0;
    assign dat_if.is_config = 1'b0;

    axis_lrelu_input_sequencer #(
        .DATA_WIDTH(DW),
        .USER_WIDTH(UW),
        .ITER_BITS (IB)
    ) u_dut (
        .aclk      (clk),
        .aresetn   (rst_n),
        .s_cfg     (cfg_if.slave),
        .s_dat     (dat_if.slave),
        .m_axis    (m_if.master),
        .iter_count(iter_count),
        .cfg_error (cfg_error)
    );

    typedef struct packed {
        logic [DW-1:0] data;
        logic [UW-1:0] user;
        logic          last;
        logic          is_cfg;
    } beat_t;

    beat_t cfg_q[$];
    beat_t dat_q[$];
    beat_t exp_q[$];

    int n_checks   = 0;
    int n_pass     = 0;
    int iters_done = 0;
    bit exp_err    = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference: each iteration is n config beats (n from kh2 of beat 0) then its data beats
    task automatic build_iter(input int kh2_mode, input int nd_fixed, input bit bad);
        beat_t b;
        int    kh2, n, nd;
        kh2 = (kh2_mode == 2) ? int'($urandom_range(0, 1)) : kh2_mode;
        n   = (kh2 != 0) ? 8 : 2;
        for (int i = 0; i < n; i++) begin
            b.data   = $urandom;
            b.user   = UW'($urandom);
            if (i == 0) b.user[0] = kh2[0];
            b.last   = (i == n - 1) || (bad && i == 0);
            b.is_cfg = 1'b1;
            cfg_q.push_back(b);
            b.last   = 1'b0;
            exp_q.push_back(b);
        end
        if (bad) exp_err = 1'b1;
        nd = (nd_fixed != 0) ? nd_fixed : int'($urandom_range(1, 5));
        for (int i = 0; i < nd; i++) begin
            b.data   = $urandom;
            b.user   = UW'($urandom);
            b.last   = (i == nd - 1);
            b.is_cfg = 1'b0;
            dat_q.push_back(b);
            exp_q.push_back(b);
        end
    endtask

    task automatic run_phase(input int n_it, input int kh2_mode, input int nd, input bit bad,
                             input int vpct, input int rpct, input bit gapless);
        int    cyc = 0, first = -1, last_c = -1, nout = 0;
        bit    cfg_v = 0, dat_v = 0, stalled = 0, hs_c, hs_d;
        beat_t held, cur, e;
        for (int i = 0; i < n_it; i++) build_iter(kh2_mode, nd, (i == 0) && bad);
        while (exp_q.size() > 0 && cyc < 5000) begin
            @(negedge clk);
            if (!cfg_v && cfg_q.size() > 0 && $urandom_range(1, 100) <= vpct) cfg_v = 1;
            if (!dat_v && dat_q.size() > 0 && $urandom_range(1, 100) <= vpct) dat_v = 1;
            cfg_if.tvalid = cfg_v;
            if (cfg_v) {cfg_if.tdata, cfg_if.tuser, cfg_if.tlast} = {cfg_q[0].data, cfg_q[0].user, cfg_q[0].last};
            dat_if.tvalid = dat_v;
            if (dat_v) {dat_if.tdata, dat_if.tuser, dat_if.tlast} = {dat_q[0].data, dat_q[0].user, dat_q[0].last};
            m_if.tready = ($urandom_range(1, 100) <= rpct);
            #1;
            check("ready_excl", 64'(cfg_if.tready & dat_if.tready), 64'd0);
            cur = {m_if.tdata, m_if.tuser, m_if.tlast, m_if.is_config};
            if (stalled) check("stall_stable", 64'({m_if.tvalid, cur}), 64'({1'b1, held}));
            if (m_if.tvalid && m_if.tready) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", 64'(cur), 64'(e));
                    if (e.last) begin
                        iters_done++;
                        check("iter_count", 64'(iter_count), 64'(iters_done % 4));
                    end
                end
                nout++;
                if (first < 0) first = cyc;
                last_c = cyc;
            end
            stalled = m_if.tvalid && !m_if.tready;
            held    = cur;
            hs_c    = cfg_v && cfg_if.tready;
            hs_d    = dat_v && dat_if.tready;
            @(posedge clk);
            if (hs_c) begin void'(cfg_q.pop_front()); cfg_v = 0; end
            if (hs_d) begin void'(dat_q.pop_front()); dat_v = 0; end
            cyc++;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
        exp_q.delete(); cfg_q.delete(); dat_q.delete();
        @(negedge clk);
        cfg_if.tvalid = 0;
        dat_if.tvalid = 0;
        m_if.tready   = 1;
        #1;
        check("cfg_error", 64'(cfg_error), 64'(exp_err));
        if (gapless) check("gapless", 64'(last_c - first + 1), 64'(nout));
    endtask

    task automatic reset_dut();
        rst_n         = 0;
        cfg_if.tvalid = 0; cfg_if.tdata = '0; cfg_if.tuser = '0; cfg_if.tlast = 0;
        dat_if.tvalid = 0; dat_if.tdata = '0; dat_if.tuser = '0; dat_if.tlast = 0;
        m_if.tready   = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n      = 1;
        iters_done = 0;
        exp_err    = 0;
    endtask

    initial begin
        reset_dut();
        #1;
        check("rst_tvalid", 64'(m_if.tvalid), 64'd0);
        check("rst_tlast", 64'(m_if.tlast), 64'd0);
        check("rst_is_config", 64'(m_if.is_config), 64'd0);
        check("rst_tdata", 64'(m_if.tdata), 64'd0);
        check("rst_iter", 64'(iter_count), 64'd0);
        check("rst_cfg_error", 64'(cfg_error), 64'd0);

        run_phase(1, 0, 4, 0, 100, 100, 1);
        run_phase(1, 1, 0, 0, 100, 100, 1);
        run_phase(3, 2, 0, 0, 70, 50, 0);
        run_phase(1, 0, 0, 1, 100, 100, 0);
        run_phase(2, 2, 0, 0, 80, 60, 0);

        // Reset while a data beat sits stalled in the output register
        @(negedge clk);
        cfg_if.tvalid = 1; cfg_if.tuser = '0; cfg_if.tlast = 0; cfg_if.tdata = 32'h11;
        m_if.tready   = 1;
        @(posedge clk);
        @(negedge clk);
        cfg_if.tlast = 1; cfg_if.tdata = 32'h22;
        @(posedge clk);
        @(negedge clk);
        cfg_if.tvalid = 0;
        dat_if.tvalid = 1; dat_if.tlast = 0; dat_if.tdata = 32'h33;
        @(posedge clk);
        @(negedge clk);
        dat_if.tvalid = 0;
        m_if.tready   = 0;
        #1;
        check("pre_rst_tvalid", 64'(m_if.tvalid), 64'd1);
        check("pre_rst_data", 64'({m_if.is_config, m_if.tdata}), 64'({1'b0, 32'h33}));
        rst_n = 0;
        #1;
        check("async_rst_tvalid", 64'(m_if.tvalid), 64'd0);
        check("async_rst_iter", 64'(iter_count), 64'd0);
        check("async_rst_cfg_error", 64'(cfg_error), 64'd0);
        @(negedge clk);
        rst_n         = 1;
        dat_if.tvalid = 1;
        #1;
        check("post_rst_ready", 64'({cfg_if.tready, dat_if.tready}), 64'({1'b1, 1'b0}));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
